tape_ctrl: RTL and testbench
============================

Name: tape_ctrl

Overview:
- Data-tape access controller placed directly upstream of the tape memory. Only this block drives the memory's read/write ports.
- Owns the data pointer and a cached copy of the current cell.
- Executes run-length tape commands from the instruction sequencer over a valid/ready handshake: cell add/sub, pointer moves, cell read-out and cell load.
- Reports cell-zero status so the sequencer can resolve loops without issuing a memory access.

Parameters:
CELL_W, 8, data cell width in bits (must match tape memory)
DEPTH, 8, number of tape cells, power of 2 (must match tape memory); ADDR_W = clog2(DEPTH) is derived internally

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-low reset (shared with tape memory)
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  controller can accept a command this cycle
cmd_op_i  in  3  opcode: 0 NOP, 1 INC, 2 DEC, 3 RIGHT, 4 LEFT, 5 READ, 6 WRITE, 7 reserved
cmd_arg_i  in  CELL_W  INC/DEC amount, RIGHT/LEFT distance (low ADDR_W bits), WRITE data
rsp_valid_o  out  1  one-cycle pulse: command completed
rsp_data_o  out  CELL_W  current cell value after the command
cell_zero_o  out  1  cached cell == 0; valid whenever cmd_ready_o=1
ptr_o  out  ADDR_W  current data pointer
mem_ren_o  out  1  tape read enable
mem_raddr_o  out  ADDR_W  tape read address
mem_rdata_i  in  CELL_W  tape read data, valid 1 cycle after mem_ren_o
mem_wen_o  out  1  tape write enable
mem_waddr_o  out  ADDR_W  tape write address
mem_wdata_o  out  CELL_W  tape write data

Behaviour:
- Reset (async, rst_i=0):
  - state=READY, ptr=0, cache=0.
  - All outputs registered and cleared to 0, except cmd_ready_o=1 and cell_zero_o=1.
  - Because the memory is cleared by the same reset, no reload is needed after reset.
- FSM states:
  - READY: cmd_ready_o=1.
  - LOAD: drive mem_ren_o=1, mem_raddr_o=ptr; cmd_ready_o=0.
  - LWAIT: capture mem_rdata_i into cache; cmd_ready_o=0.
- A command is accepted on the edge where cmd_valid_i & cmd_ready_o. Call that edge T.
- INC/DEC:
  - At T: cache <= cache ± cmd_arg_i, modulo 2^CELL_W (wraps, e.g. 0-1=0xFF).
  - Cycle after T: mem_wen_o=1, mem_waddr_o=ptr, mem_wdata_o=new cache; rsp_valid_o=1, rsp_data_o=new cache.
  - Stays in READY, so back-to-back commands are allowed every cycle.
- WRITE:
  - At T: cache <= cmd_arg_i.
  - Cycle after T: memory write and response as for INC.
- READ and NOP:
  - Cycle after T: rsp_valid_o=1, rsp_data_o=cache. No memory access.
  - Opcode 7 is treated as NOP.
- RIGHT/LEFT:
  - At T: ptr <= ptr ± cmd_arg_i[ADDR_W-1:0], modulo DEPTH (wraps 7+1=0, 0-1=7). Go to LOAD.
  - LOAD cycle: mem_ren_o=1.
  - LWAIT cycle: cache <= mem_rdata_i.
  - Then READY with rsp_valid_o=1 and rsp_data_o=new cell.
  - Accept-to-response latency is 3 cycles; cmd_ready_o is low for 2 cycles.
  - A move of 0 still performs the reload.
- mem_ren_o and mem_wen_o are single-cycle pulses.
- Write and read collisions cannot occur. A write only happens in the cycle after an INC/DEC/WRITE acceptance, a read only in the cycle after a move acceptance, and at most one command is accepted per cycle. So the two enables are never high in the same cycle.
- A write pending from the command at T-1 completes in the same cycle as the LOAD for a move accepted at T. Returning to that cell later reads the updated value.
- cell_zero_o is registered: (cache==0), updated in the same cycle as cache.
- Reset mid-operation (LOAD/LWAIT or a write pending): abort immediately to the reset values. No partial write is issued after reset deassertion.
- cmd_* inputs are ignored when cmd_ready_o=0. The sequencer must hold a command until it is accepted.

Decomposition:
- Shared package holds:
  - opcode constants OP_NOP..OP_WRITE (3-bit);
  - FSM state encoding (READY/LOAD/LWAIT);
  - default CELL_W/DEPTH constants reused by tape_memory.
- Single flat module; no sub-module needed. The pointer/cell arithmetic is simple modular add/sub.

Test Plan:
- Reset, then INC arg=3 → next cycle: mem_wen_o=1, waddr=0, wdata=0x03; rsp_data_o=0x03; cell_zero_o=0.
- DEC arg=1 at cell 0 after reset → wdata=0xFF, rsp_data_o=0xFF (underflow wrap).
- WRITE 0x5A at ptr 0; RIGHT 1; LEFT 1 → after LEFT: ptr_o=0, mem_ren_o pulse at raddr 0, rsp_data_o=0x5A 3 cycles after accept, cmd_ready_o low exactly 2 cycles.
- LEFT 1 from ptr 0 → ptr_o=7, rsp_data_o=0x00. RIGHT 9 from ptr 7 → ptr_o=0 (DEPTH=8 wrap).
- Back-to-back INC 1, INC 1, INC 1 with cmd_valid_i held → accepted on 3 consecutive cycles; wdata sequence 0x01, 0x02, 0x03; then READ → rsp_data_o=0x03.
- Assert rst_i low during the LWAIT of a move → ptr_o=0, cell_zero_o=1, cmd_ready_o=1, no rsp_valid_o pulse; next INC writes 0x01 to address 0.

Source files
------------

// File: rtl/tape_ctrl_pkg.sv
// Shared definitions for the data-tape controller and the tape memory it drives.
package tape_ctrl_pkg;

  localparam int CELL_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_INC   = 3'd1;
  localparam logic [2:0] OP_DEC   = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_LEFT  = 3'd4;
  localparam logic [2:0] OP_READ  = 3'd5;
  localparam logic [2:0] OP_WRITE = 3'd6;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_LWAIT = 2'd2
  } state_e;

endpackage

// File: rtl/tape_ctrl.sv
// Data-tape access controller: owns the pointer and a cached copy of the current cell,
// and is the only driver of the tape memory ports.
module tape_ctrl
  import tape_ctrl_pkg::*;
#(
  parameter int CELL_W = CELL_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // Command handshake: a command transfers on a rising edge where cmd_valid_i and
  // cmd_ready_o are both 1; the sequencer holds op/arg stable until then. Every accepted
  // command produces exactly one single-cycle rsp_valid_o pulse.
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [CELL_W-1:0] cmd_arg_i,
  output logic              rsp_valid_o,
  output logic [CELL_W-1:0] rsp_data_o,
  output logic              cell_zero_o,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              mem_ren_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic [CELL_W-1:0] mem_rdata_i,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [CELL_W-1:0] mem_wdata_o,
  output logic [1:0]        state_o
);

  state_e              state_q, state_d;
  logic [CELL_W-1:0]   cache_q, cache_d;
  logic [ADDR_W-1:0]   ptr_d;
  logic                cmd_ready_d, rsp_valid_d, cell_zero_d, mem_ren_d, mem_wen_d;
  logic [CELL_W-1:0]   rsp_data_d, mem_wdata_d;
  logic [ADDR_W-1:0]   mem_raddr_d, mem_waddr_d;
  logic                accept, is_move;

  assign accept  = cmd_valid_i & cmd_ready_o;
  assign is_move = (cmd_op_i == OP_RIGHT) || (cmd_op_i == OP_LEFT);
  assign state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_READY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_READY: if (accept && is_move) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_LWAIT;
      ST_LWAIT: state_d = ST_READY;
      default:  state_d = ST_READY;
    endcase
  end

  // Next values of every registered output; writes always carry the freshly updated cache.
  always_comb begin
    ptr_d       = ptr_o;
    cache_d     = cache_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_o;
    mem_ren_d   = 1'b0;
    mem_raddr_d = '0;
    mem_wen_d   = 1'b0;
    mem_waddr_d = '0;
    mem_wdata_d = '0;
    case (state_q)
      ST_READY: begin
        if (accept) begin
          case (cmd_op_i)
            OP_INC, OP_DEC, OP_WRITE: begin
              if (cmd_op_i == OP_INC)      cache_d = cache_q + cmd_arg_i;
              else if (cmd_op_i == OP_DEC) cache_d = cache_q - cmd_arg_i;
              else                         cache_d = cmd_arg_i;
              mem_wen_d   = 1'b1;
              mem_waddr_d = ptr_o;
              mem_wdata_d = cache_d;
              rsp_valid_d = 1'b1;
              rsp_data_d  = cache_d;
            end
            OP_RIGHT, OP_LEFT: begin
              if (cmd_op_i == OP_RIGHT) ptr_d = ptr_o + cmd_arg_i[ADDR_W-1:0];
              else                      ptr_d = ptr_o - cmd_arg_i[ADDR_W-1:0];
              mem_ren_d   = 1'b1;
              mem_raddr_d = ptr_d;
            end
            default: begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = cache_q;
            end
          endcase
        end
      end
      ST_LWAIT: begin
        cache_d     = mem_rdata_i;
        rsp_valid_d = 1'b1;
        rsp_data_d  = mem_rdata_i;
      end
      default: ;
    endcase
    cell_zero_d = (cache_d == '0);
    cmd_ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_o       <= '0;
      cache_q     <= '0;
      cmd_ready_o <= 1'b1;
      cell_zero_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      mem_ren_o   <= 1'b0;
      mem_raddr_o <= '0;
      mem_wen_o   <= 1'b0;
      mem_waddr_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      ptr_o       <= ptr_d;
      cache_q     <= cache_d;
      cmd_ready_o <= cmd_ready_d;
      cell_zero_o <= cell_zero_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_data_o  <= rsp_data_d;
      mem_ren_o   <= mem_ren_d;
      mem_raddr_o <= mem_raddr_d;
      mem_wen_o   <= mem_wen_d;
      mem_waddr_o <= mem_waddr_d;
      mem_wdata_o <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_tape_ctrl.sv
// Directed bench for tape_ctrl with a behavioural tape memory and queue-based scoreboard.
module tb_tape_ctrl;
  import tape_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_arg = 8'd0;
  logic       cmd_ready_o, rsp_valid_o, cell_zero_o, mem_ren_o, mem_wen_o;
  logic [7:0] rsp_data_o, mem_wdata_o, mem_rdata;
  logic [2:0] ptr_o, mem_raddr_o, mem_waddr_o;
  logic [1:0] state_o;
  logic [7:0] mem [8];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int low_run = 0;
  int a1, a2, a3, dummy;

  logic [7:0]  exp_q[$];
  int          cyc_q[$];
  logic [10:0] exp_w_q[$];
  logic [2:0]  exp_ra_q[$];

  tape_ctrl #(.CELL_W(8), .DEPTH(8)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op), .cmd_arg_i(cmd_arg),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .cell_zero_o(cell_zero_o), .ptr_o(ptr_o),
    .mem_ren_o(mem_ren_o), .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata),
    .mem_wen_o(mem_wen_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
    .state_o(state_o)
  );

  // Clock, cycle counter, watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Tape memory model: synchronous read, cleared by the shared reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'd0;
      mem_rdata <= 8'd0;
    end else begin
      if (mem_wen_o) mem[mem_waddr_o] <= mem_wdata_o;
      if (mem_ren_o) mem_rdata <= mem[mem_raddr_o];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or memory access
  always @(negedge clk) begin
    if (!rst_n) begin
      low_run = 0;
    end else begin
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else begin
          check("rsp_data", rsp_data_o, exp_q.pop_front());
          check("rsp_cycle", cyc, cyc_q.pop_front());
        end
      end
      if (mem_wen_o) begin
        if (exp_w_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else check("wr_addr_data", {mem_waddr_o, mem_wdata_o}, exp_w_q.pop_front());
      end
      if (mem_ren_o) begin
        if (exp_ra_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else check("rd_addr", mem_raddr_o, exp_ra_q.pop_front());
      end
      if (mem_wen_o || mem_ren_o) check("en_exclusive", mem_wen_o & mem_ren_o, 32'd0);
      if (!cmd_ready_o) low_run++;
      else begin
        if (low_run != 0) check("ready_low_cycles", low_run, 32'd2);
        low_run = 0;
      end
    end
  end

  // Driver: called at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [2:0] op, input logic [7:0] arg, input logic [7:0] exp_rsp,
                      input logic [2:0] exp_addr, output int acc_cyc);
    int budget = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    while (cmd_ready_o !== 1'b1 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    acc_cyc = -1;
    if (budget >= 10) begin
      check("accept_timeout", 32'd1, 32'd0);
      cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp_rsp);
    if (op == OP_RIGHT || op == OP_LEFT) begin
      cyc_q.push_back(cyc + 3);
      exp_ra_q.push_back(exp_addr);
    end else begin
      cyc_q.push_back(cyc + 1);
    end
    if (op == OP_INC || op == OP_DEC || op == OP_WRITE) exp_w_q.push_back({exp_addr, exp_rsp});
    acc_cyc = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while ((exp_q.size() + exp_w_q.size() + exp_ra_q.size()) != 0 && b < 20) begin
      @(negedge clk);
      b++;
    end
    check("drain_pending", exp_q.size() + exp_w_q.size() + exp_ra_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    check("rst_ready", cmd_ready_o, 32'd1);
    check("rst_cell_zero", cell_zero_o, 32'd1);
    check("rst_ptr", ptr_o, 32'd0);
    check("rst_rsp_valid", rsp_valid_o, 32'd0);
    check("rst_rsp_data", rsp_data_o, 32'd0);
    check("rst_enables", {mem_ren_o, mem_wen_o}, 32'd0);
    check("rst_state", state_o, 32'd0);

    // INC 3 after reset
    send(OP_INC, 8'd3, 8'h03, 3'd0, dummy);
    drain();
    check("inc_cell_zero", cell_zero_o, 32'd0);

    // DEC 1 from a zero cell wraps
    do_reset();
    send(OP_DEC, 8'd1, 8'hFF, 3'd0, dummy);
    drain();

    // WRITE, moves and pointer wrap
    do_reset();
    send(OP_WRITE, 8'h5A, 8'h5A, 3'd0, dummy);
    send(OP_RIGHT, 8'd1, 8'h00, 3'd1, dummy);
    drain();
    check("right1_ptr", ptr_o, 32'd1);
    check("right1_zero", cell_zero_o, 32'd1);
    send(OP_LEFT, 8'd1, 8'h5A, 3'd0, dummy);
    drain();
    check("left1_ptr", ptr_o, 32'd0);
    check("left1_zero", cell_zero_o, 32'd0);
    send(OP_LEFT, 8'd1, 8'h00, 3'd7, dummy);
    drain();
    check("left_wrap_ptr", ptr_o, 32'd7);
    send(OP_RIGHT, 8'd9, 8'h5A, 3'd0, dummy);
    drain();
    check("right9_ptr", ptr_o, 32'd0);

    // Write immediately followed by a zero-distance move sees the new value
    send(OP_INC, 8'd1, 8'h5B, 3'd0, dummy);
    send(OP_RIGHT, 8'd0, 8'h5B, 3'd0, dummy);
    send(OP_LEFT, 8'd1, 8'h00, 3'd7, dummy);
    send(OP_RIGHT, 8'd1, 8'h5B, 3'd0, dummy);
    drain();

    // Back-to-back INCs, then non-memory commands
    do_reset();
    send(OP_INC, 8'd1, 8'h01, 3'd0, a1);
    send(OP_INC, 8'd1, 8'h02, 3'd0, a2);
    send(OP_INC, 8'd1, 8'h03, 3'd0, a3);
    check("b2b_accept_1", a2 - a1, 32'd1);
    check("b2b_accept_2", a3 - a2, 32'd1);
    send(OP_READ, 8'd0, 8'h03, 3'd0, dummy);
    send(OP_NOP, 8'd0, 8'h03, 3'd0, dummy);
    send(3'd7, 8'h44, 8'h03, 3'd0, dummy);
    send(OP_DEC, 8'd4, 8'hFF, 3'd0, dummy);
    send(OP_INC, 8'd1, 8'h00, 3'd0, dummy);
    drain();
    check("wrap_to_zero", cell_zero_o, 32'd1);

    // Reset during LWAIT of a move aborts it
    send(OP_INC, 8'd7, 8'h07, 3'd0, dummy);
    drain();
    cmd_valid = 1'b1; cmd_op = OP_RIGHT; cmd_arg = 8'd2;
    exp_ra_q.push_back(3'd2);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("abort_ptr", ptr_o, 32'd0);
    check("abort_zero", cell_zero_o, 32'd1);
    check("abort_ready", cmd_ready_o, 32'd1);
    check("abort_rsp", rsp_valid_o, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_rsp", rsp_valid_o, 32'd0);
    check("abort_no_wr", mem_wen_o, 32'd0);
    send(OP_INC, 8'd1, 8'h01, 3'd0, dummy);
    drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
